// File: rtl/weight_loader_pkg.sv
// Shared configuration and state encoding for the weight loader.
package weight_loader_pkg;

   // Default tile geometry shared with weight_buffer and the systolic array.
   localparam int unsigned WL_ARRAYWIDTH  = 4;
   localparam int unsigned WL_ARRAYHEIGHT = 4;
   localparam int unsigned WL_DATASIZE    = 8;
   localparam int unsigned WL_ADDRWIDTH   = 10;

   // Fixed encodings so the controller can decode the loader state for debug.
   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFetch = 3'd1,
      StFlush = 3'd2,
      StDrain = 3'd3,
      StDone  = 3'd4
   } wl_state_e;

endpackage

// File: rtl/weight_loader.sv
// Weight loader: fetches one ARRAYHEIGHT-row weight tile from SRAM, pushes the
// rows into weight_buffer with load_en, then shifts them out with out_en.
module weight_loader
   import weight_loader_pkg::*;
#(
   parameter int unsigned ARRAYWIDTH  = WL_ARRAYWIDTH,
   parameter int unsigned ARRAYHEIGHT = WL_ARRAYHEIGHT,
   parameter int unsigned DATASIZE    = WL_DATASIZE,
   parameter int unsigned ADDRWIDTH   = WL_ADDRWIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [ADDRWIDTH-1:0]           base_addr,
   input  logic                           stall,
   output logic                           busy,
   output logic                           done,
   output logic                           mem_rd_en,
   output logic [ADDRWIDTH-1:0]           mem_addr,
   input  logic [ARRAYWIDTH*DATASIZE-1:0] mem_rd_data,
   output logic                           load_en,
   output logic [ARRAYWIDTH*DATASIZE-1:0] wb_weight,
   output logic                           out_en
);

   localparam int unsigned CntWidth = $clog2(ARRAYHEIGHT + 1);
   localparam logic [CntWidth-1:0] LastRow = CntWidth'(ARRAYHEIGHT - 1);
   localparam logic [CntWidth-1:0] Height  = CntWidth'(ARRAYHEIGHT);

   wl_state_e               state_q, state_d;
   logic [ADDRWIDTH-1:0]    addr_q, addr_d;
   logic [CntWidth-1:0]     rd_cnt_q, rd_cnt_d;
   logic [CntWidth-1:0]     dr_cnt_q, dr_cnt_d;

   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    mem_rd_en_q, mem_rd_en_d;
   logic [ADDRWIDTH-1:0]    mem_addr_q, mem_addr_d;
   logic                    load_en_q, load_en_d;
   logic                    out_en_q, out_en_d;

   // State, base address and counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         rd_cnt_q <= '0;
         dr_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rd_cnt_q <= rd_cnt_d;
         dr_cnt_q <= dr_cnt_d;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rd_cnt_d = rd_cnt_q;
      dr_cnt_d = dr_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StFetch;
               addr_d   = base_addr;
               rd_cnt_d = '0;
            end
         end
         StFetch: begin
            rd_cnt_d = rd_cnt_q + CntWidth'(1);
            if (rd_cnt_q == LastRow) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            state_d  = StDrain;
            dr_cnt_d = '0;
         end
         StDrain: begin
            // A beat is counted once it has actually been presented on out_en.
            dr_cnt_d = dr_cnt_q + CntWidth'(out_en_q);
            if (dr_cnt_d == Height) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Registered-output next values, derived from the upcoming state.
   always_comb begin
      mem_rd_en_d = (state_d == StFetch);
      mem_addr_d  = mem_addr_q;
      if (state_d == StFetch) begin
         // Address wraps modulo 2^ADDRWIDTH by truncation.
         mem_addr_d = addr_d + ADDRWIDTH'(rd_cnt_d);
      end
      // SRAM data lands one cycle after the read strobe.
      load_en_d = mem_rd_en_q;
      // Entering DRAIN implies fewer than ARRAYHEIGHT beats have been issued.
      out_en_d  = (state_d == StDrain) && !stall;
      done_d    = (state_d == StDone);
      busy_d    = (state_d != StIdle);
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_rd_en_q <= 1'b0;
         mem_addr_q  <= '0;
         load_en_q   <= 1'b0;
         out_en_q    <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         done_q      <= done_d;
         mem_rd_en_q <= mem_rd_en_d;
         mem_addr_q  <= mem_addr_d;
         load_en_q   <= load_en_d;
         out_en_q    <= out_en_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_rd_en = mem_rd_en_q;
   assign mem_addr  = mem_addr_q;
   assign load_en   = load_en_q;
   assign out_en    = out_en_q;
   assign wb_weight = mem_rd_data;

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Upstream feeder for weight_buffer.
- On a start pulse it fetches ARRAYHEIGHT consecutive weight rows from the weight SRAM, one row per address. Each row is ARRAYWIDTH x DATASIZE bits.
- It pushes each row into the per-column shift registers with load_en, then drives out_en for ARRAYHEIGHT beats to shift the tile into the systolic array.
- Handshakes: start/busy/done to the controller; stall from the array.

Parameters:
- ARRAYWIDTH, default `ARRAYWIDTH (4): number of columns (lanes per row).
- ARRAYHEIGHT, default `ARRAYHEIGHT (4): number of rows per weight tile.
- DATASIZE, default `DATASIZE (8): bits per weight element.
- ADDRWIDTH, default 10: weight SRAM address width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous active-low reset; asserting it (rst=0) clears all state immediately.
- start, input, 1: begin tile load; sampled only in IDLE.
- base_addr, input, ADDRWIDTH: first SRAM row address; captured when start is accepted.
- stall, input, 1: array not ready; holds the DRAIN phase.
- busy, output, 1: high from the cycle after start is accepted until the cycle after the done pulse.
- done, output, 1: one-cycle pulse when the tile has been fully shifted out.
- mem_rd_en, output, 1: SRAM read strobe.
- mem_addr, output, ADDRWIDTH: SRAM read address.
- mem_rd_data, input, ARRAYWIDTH*DATASIZE: SRAM read data, valid exactly 1 cycle after mem_rd_en.
- load_en, output, 1: to weight_buffer load_en.
- wb_weight, output, ARRAYWIDTH*DATASIZE: to weight_buffer in_weight; lane i occupies [(i+1)*DATASIZE-1 : i*DATASIZE].
- out_en, output, 1: to weight_buffer out_en.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; counters=0; busy, done, mem_rd_en, load_en and out_en all 0; mem_addr=0.
  - Reset mid-operation abandons the tile. Rows partially loaded into weight_buffer are not cleaned up by this block.
- wb_weight = mem_rd_data, combinational pass-through. It is meaningful only while load_en=1.
- mem_rd_en, mem_addr, load_en, out_en, busy and done are all registered outputs.

FSM states: IDLE, FETCH, FLUSH, DRAIN, DONE.
- IDLE:
  - start=1 -> capture base_addr into addr_q, rd_cnt=0, go to FETCH.
  - start is ignored in every other state; there is no queuing.
- FETCH:
  - mem_rd_en=1 every cycle, mem_addr=addr_q+rd_cnt.
  - Address arithmetic is modulo 2^ADDRWIDTH, so the address wraps from all-ones to 0 without error.
  - After ARRAYHEIGHT reads go to FLUSH.
- Load path: load_en is mem_rd_en delayed by 1 cycle, so load_en pulses exactly ARRAYHEIGHT times on consecutive cycles.
- FLUSH: one cycle, covering the last load_en beat. Then go to DRAIN with dr_cnt=0.
- DRAIN:
  - out_en = !stall, registered so that out_en in cycle t reflects stall sampled at edge t.
  - dr_cnt increments on each out_en beat.
  - Go to DONE when dr_cnt reaches ARRAYHEIGHT.
  - stall may toggle arbitrarily; the number of out_en beats is always exactly ARRAYHEIGHT.
- DONE: done=1 for one cycle, then go to IDLE. busy drops in that IDLE cycle.
- Invariants:
  - load_en and out_en are never high in the same cycle.
  - mem_rd_en is never high outside FETCH.
- Latency, no stall: start sampled at edge 0 -> first mem_rd_en at cycle 1 -> load_en cycles 2..H+1 -> out_en cycles H+2..2H+1 -> done at cycle 2H+2. Total 2H+2 cycles.
- A start pulse held for many cycles starts exactly one tile. If start is still high on return to IDLE, a new tile begins.

Decomposition:
- Add ARRAYHEIGHT next to ARRAYWIDTH/DATASIZE in the shared config header.
- Add the state encodings (IDLE=0, FETCH=1, FLUSH=2, DRAIN=3, DONE=4, 3 bits) as shared `defines so the top-level controller can decode the state for debug.
- Counter width is $clog2(ARRAYHEIGHT+1).
- No sub-module: FSM, two counters and the read-latency register are implemented in one module.

Test Plan:
- Basic load, H=W=4, D=8, SRAM rows 0x10..0x13 holding 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D; start with base=0x10 -> mem_addr 0x10..0x13 in cycles 1..4; load_en cycles 2..5 carrying those four words in order; out_en cycles 6..9; done=1 at cycle 10; busy high over cycles 1..10.
- Address wrap, ADDRWIDTH=10, base=0x3FE -> mem_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
- Stall during DRAIN: stall=1 for 3 cycles after the 2nd out_en beat -> out_en gaps for exactly those cycles; total out_en beats=4; done delayed to cycle 13.
- Start while busy: pulse start at cycle 3 -> ignored; one tile only; done at cycle 10.
- Reset mid-FETCH: rst=0 at cycle 3 -> all outputs 0 immediately, without waiting for a clock edge. A new start after release -> normal sequence from base.
- Back-to-back tiles: start held high -> second tile's first mem_rd_en occurs 2 cycles after the first tile's done pulse (one IDLE cycle, then FETCH); load_en and out_en never overlap throughout.
